pf_clk_div_delay_ctrl: RTL
==========================

// Module: pf_clk_div_delay_ctrl
// PURPOSE
//  Sequencer for the ICB_CLKDIVDELAY clock divider/delay cell in the LVDS RX clock path.
//  Runs the divider reset-release sequence and loads the delay line.
//  Steps the delay line tap-by-tap to a commanded target and issues single BIT_SLIP pulses on request.
//  Flags delay-line out-of-range as a sticky fault. Sits between RX training logic and the CDD primitive.
// PARAMETERS
//  TAP_W          8   width of delay tap index
//  RST_CYCLES     16  cycles CDD_RST_N held low after RESET (>=1)
//  SETTLE_CYCLES  4   idle cycles after every MOVE/BIT_SLIP pulse (>=1)
// PORTS
//  CLK               in   1      controller clock (divided fabric clock)
//  RESET             in   1      synchronous reset, active-high
//  CMD_VALID         in   1      new target tap valid
//  CMD_TAP           in   TAP_W  target tap
//  CMD_READY         out  1      controller accepts command
//  SLIP_REQ          in   1      one-cycle bit-slip request pulse
//  SLIP_DONE         out  1      one-cycle pulse: slip settled
//  CDD_RST_N         out  1      to CDD RST_N
//  CDD_DELAY_LOAD    out  1      to CDD DELAY_LINE_LOAD
//  CDD_DELAY_MOVE    out  1      to CDD DELAY_LINE_MOVE
//  CDD_DELAY_DIR     out  1      to CDD DELAY_LINE_DIR (1 = increment)
//  CDD_BIT_SLIP      out  1      to CDD BIT_SLIP
//  CDD_OUT_OF_RANGE  in   1      from CDD DELAY_LINE_OUT_OF_RANGE
//  CUR_TAP           out  TAP_W  current tap after last MOVE
//  LOCKED            out  1      high in IDLE with no work pending
//  ERR               out  1      sticky out-of-range fault
// BEHAVIOUR
//  Reset (RESET=1 at an edge, any state): next cycle all outputs 0, CUR_TAP=0, slip pending cleared, state RST_HOLD.
//  RST_HOLD: CDD_RST_N=0 for RST_CYCLES cycles -> LOAD.
//  LOAD: CDD_RST_N=1; CDD_DELAY_LOAD=1 for one cycle; CUR_TAP=0 -> SETTLE -> IDLE.
//  IDLE: CMD_READY=1; LOCKED=1 unless slip pending. CMD_VALID&CMD_READY latches CMD_TAP as target.
//   target==CUR_TAP: no pulses, stays IDLE. Otherwise -> STEP.
//  STEP: one-cycle CDD_DELAY_MOVE; DIR=(target>CUR_TAP); DIR stable from STEP through SETTLE.
//   CUR_TAP +/-1 in same cycle -> SETTLE.
//  Latency: first MOVE in cycle after accept; each tap costs 1+SETTLE_CYCLES cycles.
//  SETTLE: SETTLE_CYCLES cycles. Then -> STEP if CUR_TAP!=target.
//   Else -> SLIP_DONE pulse if the settle followed a slip, then IDLE.
//  CMD_READY=0 and LOCKED=0 outside IDLE. CMD_VALID outside IDLE is ignored; source holds it.
//  CUR_TAP never wraps: increment at 2^TAP_W-1 or decrement at 0 -> FAULT, no MOVE issued.
//  SLIP_REQ pulse in any non-FAULT state sets slip-pending. Further pulses while pending merge into one.
//  Pending slip is serviced from IDLE when no CMD_VALID that cycle; a command wins on a simultaneous event.
//  Slip service: CDD_BIT_SLIP=1 one cycle -> SETTLE -> SLIP_DONE=1 one cycle -> IDLE.
//  CDD_OUT_OF_RANGE sampled high in SETTLE -> FAULT.
//  FAULT: ERR=1, CMD_READY=0, LOCKED=0, no pulses. CUR_TAP frozen. Exit only via RESET.
//  All outputs registered; MOVE/LOAD/BIT_SLIP never asserted in same cycle.
// CONFIGURATION
//  CLK_DIV_DELAY_CTRL_STATS_EN defined:
//   adds out port MOVE_COUNT[15:0]: saturating count of CDD_DELAY_MOVE pulses since RESET (holds 16'hFFFF);
//   adds out port SLIP_COUNT[7:0]: saturating count of CDD_BIT_SLIP pulses.
//   Both reset to 0.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  RESET 1 cycle -> CDD_RST_N low 16 cycles, one LOAD pulse, CMD_READY=1 at cycle 16+1+4+1.
//  CMD_TAP=3 from tap 0 -> 3 MOVE pulses DIR=1, 5 cycles apart, CUR_TAP=3, LOCKED=1.
//  CMD_TAP=1 from 3 -> 2 MOVE DIR=0. Then CMD_TAP=1 -> no MOVE, CMD_READY stays 1.
//  SLIP_REQ and CMD_VALID same IDLE cycle -> moves complete first, then one BIT_SLIP.
//   SLIP_DONE 5 cycles after BIT_SLIP.
//  CDD_OUT_OF_RANGE=1 during SETTLE of tap 2 -> ERR=1 sticky, no further pulses.
//   RESET clears ERR, CUR_TAP=0.
//  RESET asserted mid-STEP at tap 100 -> outputs zero next cycle, full init sequence reruns.
//   With STATS_EN: MOVE_COUNT resets to 0.

Source files
------------

// File: rtl/pf_clk_div_delay_ctrl.sv
// pf_clk_div_delay_ctrl
//   Sequencer for the ICB_CLKDIVDELAY divider/delay cell in the LVDS RX clock path.
//   It runs the divider reset-release sequence, loads the delay line, steps the delay
//   line one tap at a time toward a commanded target and issues single BIT_SLIP pulses
//   on request. An out-of-range report from the cell is latched as a sticky fault.
//
// Parameters
//   TAP_W          width of the delay tap index
//   RST_CYCLES     cycles CDD_RST_N is held low after RESET (>= 1)
//   SETTLE_CYCLES  idle cycles after every MOVE / BIT_SLIP / LOAD pulse (>= 1)
//
// Ports
//   CLK, RESET          controller clock, synchronous active-high reset
//   CMD_VALID/CMD_TAP   target tap command, accepted when CMD_READY is high
//   CMD_READY           high only in IDLE
//   SLIP_REQ            one-cycle bit-slip request (requests merge while pending)
//   SLIP_DONE           one-cycle pulse once a slip has settled
//   CDD_*               drive / status of the clock divider-delay cell
//   CUR_TAP             tap reached by the last MOVE
//   LOCKED              IDLE with no slip pending
//   ERR                 sticky out-of-range fault, cleared only by RESET
//
// Build option
//   CLK_DIV_DELAY_CTRL_STATS_EN adds MOVE_COUNT[15:0] and SLIP_COUNT[7:0], saturating
//   counts of CDD_DELAY_MOVE and CDD_BIT_SLIP pulses since RESET.

module pf_clk_div_delay_ctrl #(
    parameter int unsigned TAP_W         = 8,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    input  logic [TAP_W-1:0] CMD_TAP,
    output logic             CMD_READY,
    input  logic             SLIP_REQ,
    output logic             SLIP_DONE,
    output logic             CDD_RST_N,
    output logic             CDD_DELAY_LOAD,
    output logic             CDD_DELAY_MOVE,
    output logic             CDD_DELAY_DIR,
    output logic             CDD_BIT_SLIP,
    input  logic             CDD_OUT_OF_RANGE,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             LOCKED,
    output logic             ERR
`ifdef CLK_DIV_DELAY_CTRL_STATS_EN
    ,
    output logic [15:0]      MOVE_COUNT,
    output logic [7:0]       SLIP_COUNT
`endif
);

    localparam logic [15:0] RstLast    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] SettleLast = 16'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StRstHold,
        StLoad,
        StSettle,
        StIdle,
        StStep,
        StSlip,
        StSlipDone,
        StFault
    } state_e;

    state_e             state_q;
    logic [15:0]        cnt_q;
    logic [TAP_W-1:0]   target_q;
    logic [TAP_W-1:0]   cur_tap_q;
    logic               slip_pend_q;
    logic               after_slip_q;   // current SETTLE follows a BIT_SLIP

    logic ready_q, locked_q, slip_done_q, rst_n_q, load_q, move_q, dir_q, bit_slip_q, err_q;

    // Next-step decision, shared by IDLE (new command) and SETTLE (continue walking).
    logic [TAP_W-1:0] step_tgt;
    logic             step_need;
    logic             step_up;
    logic             step_wrap;
    logic             service_slip;
    logic             slip_pend_d;

    always_comb begin
        step_tgt     = (state_q == StIdle) ? CMD_TAP : target_q;
        step_need    = (step_tgt != cur_tap_q);
        step_up      = (step_tgt > cur_tap_q);
        step_wrap    = step_up ? (cur_tap_q == {TAP_W{1'b1}}) : (cur_tap_q == '0);
        // A command in the same IDLE cycle wins; the slip waits for the next IDLE.
        service_slip = (state_q == StIdle) && !CMD_VALID && slip_pend_q;
        if (state_q == StFault) begin
            slip_pend_d = slip_pend_q;
        end else begin
            slip_pend_d = (slip_pend_q && !service_slip) || SLIP_REQ;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= StRstHold;
            cnt_q        <= '0;
            target_q     <= '0;
            cur_tap_q    <= '0;
            slip_pend_q  <= 1'b0;
            after_slip_q <= 1'b0;
            ready_q      <= 1'b0;
            locked_q     <= 1'b0;
            slip_done_q  <= 1'b0;
            rst_n_q      <= 1'b0;
            load_q       <= 1'b0;
            move_q       <= 1'b0;
            dir_q        <= 1'b0;
            bit_slip_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            slip_pend_q <= slip_pend_d;
            // Pulses and IDLE-only flags default low; branches entering IDLE raise them.
            load_q      <= 1'b0;
            move_q      <= 1'b0;
            bit_slip_q  <= 1'b0;
            slip_done_q <= 1'b0;
            ready_q     <= 1'b0;
            locked_q    <= 1'b0;

            unique case (state_q)
                StRstHold: begin
                    if (cnt_q == RstLast) begin
                        state_q   <= StLoad;
                        rst_n_q   <= 1'b1;
                        load_q    <= 1'b1;
                        cur_tap_q <= '0;
                        target_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StLoad: begin
                    state_q      <= StSettle;
                    cnt_q        <= '0;
                    after_slip_q <= 1'b0;
                end

                StSettle: begin
                    if (CDD_OUT_OF_RANGE) begin
                        state_q <= StFault;
                        err_q   <= 1'b1;
                    end else if (cnt_q == SettleLast) begin
                        if (step_need) begin
                            if (step_wrap) begin
                                state_q <= StFault;
                                err_q   <= 1'b1;
                            end else begin
                                state_q   <= StStep;
                                move_q    <= 1'b1;
                                dir_q     <= step_up;
                                cur_tap_q <= step_up ? cur_tap_q + TAP_W'(1)
                                                     : cur_tap_q - TAP_W'(1);
                            end
                        end else if (after_slip_q) begin
                            state_q     <= StSlipDone;
                            slip_done_q <= 1'b1;
                        end else begin
                            state_q  <= StIdle;
                            ready_q  <= 1'b1;
                            locked_q <= !slip_pend_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StIdle: begin
                    if (CMD_VALID) begin
                        target_q <= CMD_TAP;
                        if (!step_need) begin
                            ready_q  <= 1'b1;
                            locked_q <= !slip_pend_d;
                        end else if (step_wrap) begin
                            state_q <= StFault;
                            err_q   <= 1'b1;
                        end else begin
                            state_q   <= StStep;
                            move_q    <= 1'b1;
                            dir_q     <= step_up;
                            cur_tap_q <= step_up ? cur_tap_q + TAP_W'(1)
                                                 : cur_tap_q - TAP_W'(1);
                        end
                    end else if (service_slip) begin
                        state_q    <= StSlip;
                        bit_slip_q <= 1'b1;
                    end else begin
                        ready_q  <= 1'b1;
                        locked_q <= !slip_pend_d;
                    end
                end

                StStep: begin
                    state_q      <= StSettle;
                    cnt_q        <= '0;
                    after_slip_q <= 1'b0;
                end

                StSlip: begin
                    state_q      <= StSettle;
                    cnt_q        <= '0;
                    after_slip_q <= 1'b1;
                end

                StSlipDone: begin
                    state_q  <= StIdle;
                    ready_q  <= 1'b1;
                    locked_q <= !slip_pend_d;
                end

                StFault: begin
                    // Frozen until RESET; err_q stays set.
                    state_q <= StFault;
                end
            endcase
        end
    end

    assign CMD_READY      = ready_q;
    assign LOCKED         = locked_q;
    assign SLIP_DONE      = slip_done_q;
    assign CDD_RST_N      = rst_n_q;
    assign CDD_DELAY_LOAD = load_q;
    assign CDD_DELAY_MOVE = move_q;
    assign CDD_DELAY_DIR  = dir_q;
    assign CDD_BIT_SLIP   = bit_slip_q;
    assign CUR_TAP        = cur_tap_q;
    assign ERR            = err_q;

`ifdef CLK_DIV_DELAY_CTRL_STATS_EN
    logic [15:0] move_cnt_q;
    logic [7:0]  slip_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            move_cnt_q <= '0;
            slip_cnt_q <= '0;
        end else begin
            if (move_q && (move_cnt_q != 16'hFFFF)) begin
                move_cnt_q <= move_cnt_q + 16'd1;
            end
            if (bit_slip_q && (slip_cnt_q != 8'hFF)) begin
                slip_cnt_q <= slip_cnt_q + 8'd1;
            end
        end
    end

    assign MOVE_COUNT = move_cnt_q;
    assign SLIP_COUNT = slip_cnt_q;
`endif

endmodule
